// File: rtl/vga_timing_gen.sv
// 1440x900@60 raster timing generator with colour blanking and a PIPE_EXT-deep delay line.
// Optional VGA_TEST_PATTERN_EN adds a test_mode input that replaces rgb_in with 8 vertical colour bars.
module vga_timing_gen #(
    parameter int   H_VIS    = 1440,
    parameter int   H_FP     = 80,
    parameter int   H_SYNC   = 152,
    parameter int   H_BP     = 232,
    parameter int   V_VIS    = 900,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 28,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b1,
    parameter int   PIPE_EXT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [3:0]  rgb_in_r,
    input  logic [3:0]  rgb_in_g,
    input  logic [3:0]  rgb_in_b,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [10:0] draw_x,
    output logic [9:0]  draw_y,
    output logic        active,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic [15:0] frame_cnt
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
    localparam logic [10:0] HS_BEG   = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    localparam int DW = 6;
`else
    localparam int DW = 3;
`endif
    // Delay-line word: {bar index (pattern builds only), active, vsync, hsync}
    localparam logic [DW-1:0] DLY_RST = DW'({1'b0, ~V_POL, ~H_POL});

    logic [10:0]   h_cnt_reg;
    logic [9:0]    v_cnt_reg;
    logic [15:0]   frame_cnt_reg;
    logic          hs_reg;
    logic          vs_reg;
    logic [11:0]   rgb_reg;
    logic          hs_raw;
    logic          vs_raw;
    logic [DW-1:0] dly_in;
    logic [DW-1:0] dly_tap;
    logic [11:0]   rgb_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (pix_en) begin
            if (h_cnt_reg == H_LAST) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 11'd1;
            end
        end
    end

    assign frame_start = pix_en && (h_cnt_reg == 11'd0) && (v_cnt_reg == 10'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (frame_start) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign active = (h_cnt_reg < H_VIS_C) && (v_cnt_reg < V_VIS_C);
    assign hs_raw = ((h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END)) ? H_POL : ~H_POL;
    assign vs_raw = ((v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END)) ? V_POL : ~V_POL;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_raw;
    assign bar_raw = 3'(h_cnt_reg / 11'd180);
    assign dly_in  = {bar_raw, active, vs_raw, hs_raw};
`else
    assign dly_in  = {active, vs_raw, hs_raw};
`endif

    generate
        if (PIPE_EXT == 0) begin : g_no_dly
            assign dly_tap = dly_in;
        end else begin : g_dly
            for (genvar gi = 0; gi < PIPE_EXT; gi++) begin : g_stage
                logic [DW-1:0] q_reg;
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n)      q_reg <= DLY_RST;
                        else if (pix_en) q_reg <= dly_in;
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n)      q_reg <= DLY_RST;
                        else if (pix_en) q_reg <= g_stage[gi-1].q_reg;
                    end
                end
            end
            assign dly_tap = g_stage[PIPE_EXT-1].q_reg;
        end
    endgenerate

    always_comb begin
        rgb_src = {rgb_in_r, rgb_in_g, rgb_in_b};
`ifdef VGA_TEST_PATTERN_EN
        // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to one bit per channel
        if (test_mode) begin
            rgb_src = {{4{~dly_tap[4]}}, {4{~dly_tap[5]}}, {4{~dly_tap[3]}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_reg  <= ~H_POL;
            vs_reg  <= ~V_POL;
            rgb_reg <= '0;
        end else if (pix_en) begin
            hs_reg  <= dly_tap[0];
            vs_reg  <= dly_tap[1];
            rgb_reg <= dly_tap[2] ? rgb_src : 12'h000;
        end
    end

    assign draw_x    = h_cnt_reg;
    assign draw_y    = v_cnt_reg;
    assign frame_cnt = frame_cnt_reg;
    assign vga_hs    = hs_reg;
    assign vga_vs    = vs_reg;
    assign vga_r     = rgb_reg[11:8];
    assign vga_g     = rgb_reg[7:4];
    assign vga_b     = rgb_reg[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster; expected values come from
// the pixel-enable count using plain modular arithmetic.
module tb_vga_timing_gen;

    localparam int   T_H_VIS = 40, T_H_FP = 4, T_H_SYNC = 6, T_H_BP = 10;
    localparam int   T_V_VIS = 20, T_V_FP = 1, T_V_SYNC = 3, T_V_BP = 4;
    localparam int   T_PIPE  = 2;
    localparam logic T_H_POL = 1'b0;
    localparam logic T_V_POL = 1'b1;
    localparam int   T_H_TOT = T_H_VIS + T_H_FP + T_H_SYNC + T_H_BP;
    localparam int   T_V_TOT = T_V_VIS + T_V_FP + T_V_SYNC + T_V_BP;
    localparam int   T_FRAME = T_H_TOT * T_V_TOT;
    localparam int   T_LAT   = T_PIPE + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [11:0] rgb;
    logic [10:0] draw_x;
    logic [9:0]  draw_y;
    logic        active, frame_start, vga_hs, vga_vs;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_pix;          // pix_en edges since reset release
    logic [11:0] last_rgb;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VIS(T_H_VIS), .H_FP(T_H_FP), .H_SYNC(T_H_SYNC), .H_BP(T_H_BP),
        .V_VIS(T_V_VIS), .V_FP(T_V_FP), .V_SYNC(T_V_SYNC), .V_BP(T_V_BP),
        .H_POL(T_H_POL), .V_POL(T_V_POL), .PIPE_EXT(T_PIPE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .rgb_in_r(rgb[11:8]), .rgb_in_g(rgb[7:4]), .rgb_in_b(rgb[3:0]),
        .draw_x(draw_x), .draw_y(draw_y), .active(active), .frame_start(frame_start),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_cnt(frame_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (pix %0d, t=%0t)", tag, got, exp, n_pix, $time);
        end
    endtask

    function automatic int pos_h(input int k);
        return k % T_H_TOT;
    endfunction

    function automatic int pos_v(input int k);
        return (k / T_H_TOT) % T_V_TOT;
    endfunction

    task automatic check_all();
        int h, v, k, kh, kv;
        logic e_act, e_hs, e_vs, e_oact;
        logic [11:0] e_rgb;
        h = pos_h(n_pix);
        v = pos_v(n_pix);
        e_act = (h < T_H_VIS) && (v < T_V_VIS);
        k = n_pix - T_LAT;
        if (k < 0) begin
            e_hs = ~T_H_POL;
            e_vs = ~T_V_POL;
            e_oact = 1'b0;
        end else begin
            kh = pos_h(k);
            kv = pos_v(k);
            e_hs = (kh >= T_H_VIS + T_H_FP && kh < T_H_VIS + T_H_FP + T_H_SYNC) ? T_H_POL : ~T_H_POL;
            e_vs = (kv >= T_V_VIS + T_V_FP && kv < T_V_VIS + T_V_FP + T_V_SYNC) ? T_V_POL : ~T_V_POL;
            e_oact = (kh < T_H_VIS) && (kv < T_V_VIS);
        end
        e_rgb = e_oact ? last_rgb : 12'h000;
        check_val("draw_x", 32'(draw_x), 32'(h));
        check_val("draw_y", 32'(draw_y), 32'(v));
        check_val("active", 32'(active), 32'(e_act));
        check_val("frame_cnt", 32'(frame_cnt), 32'(((n_pix + T_FRAME - 1) / T_FRAME) & 16'hFFFF));
        check_val("vga_hs", 32'(vga_hs), 32'(e_hs));
        check_val("vga_vs", 32'(vga_vs), 32'(e_vs));
        check_val("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    endtask

    task automatic check_fs();
        logic e_fs;
        e_fs = pix_en && (pos_h(n_pix) == 0) && (pos_v(n_pix) == 0);
        check_val("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    initial begin
        rst_n    = 1'b0;
        pix_en   = 1'b0;
        rgb      = 12'h000;
        n_pix    = 0;
        last_rgb = 12'h000;
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 9000; cyc++) begin
            if (cyc < 2500)      pix_en = 1'b1;
            else if (cyc < 4500) pix_en = (cyc % 2 == 0);
            else                 pix_en = ($urandom_range(0, 3) != 0);
            // Mostly random colour, with stretches of full white to expose blanking
            rgb = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            #1;
            check_fs();
            if (cyc == 5200) begin
                #2;
                rst_n    = 1'b0;
                n_pix    = 0;
                last_rgb = 12'h000;
                #1;
                check_all();
                check_fs();
            end
            @(posedge clk);
            if (rst_n && pix_en) begin
                n_pix++;
                last_rgb = rgb;
            end
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            check_all();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
